step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
Timing generator and instruction decoder for the hardwired control unit. It accepts an opcode and a start request, then drives the one-hot time-step bus T and the one-hot instruction bus Ins that the control-signal encoder consumes. It advances T once per clock while Run is high and terminates the instruction when the encoder returns End. It is the producer side of the T/Ins/End interface.

Parameters:
NSTEPS, 16, width of the one-hot T bus and maximum steps per instruction (4..16).
OPW, 4, opcode width; codes 0..3 are legal, all others are illegal.

Ports:
Clk  input  1  clock; all state changes on the rising edge.
Resetn  input  1  synchronous reset, active-low.
Start  input  1  request to begin an instruction; sampled only in IDLE.
Opcode  input  OPW  instruction code: 0=Add, 1=Sub, 2=Mul, 3=Div.
Run  input  1  step enable; 0 stalls the sequencer.
End  input  1  end-of-instruction from the encoder.
T  output  NSTEPS  one-hot time step; all zeros when idle.
Ins  output  4  one-hot decoded instruction (bit0 Add, bit1 Sub, bit2 Mul, bit3 Div); zero when idle.
Step  output  4  binary index of the active T bit; 0 when idle.
Busy  output  1  high in RUN state.
Done  output  1  one-cycle pulse on normal completion.
Err  output  1  sticky error flag (illegal opcode or step overflow).

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous, active-low (Resetn). Resetn=0 at an edge gives T=0, Ins=0, Step=0, Busy=0, Done=0, Err=0, state IDLE. Reset overrides all other inputs, including mid-instruction.
- States: IDLE, RUN. All outputs are registered.
- IDLE. Done and Err values follow the rules below; T=0, Ins=0, Step=0, Busy=0.
  - Start=1, Run=1, Opcode<=3: next cycle state=RUN, T=1, Step=0, Ins=1<<Opcode, Busy=1, Err cleared, Done=0.
  - Start=1, Run=1, Opcode>3: stay in IDLE, Err=1, T stays 0.
  - Start=1 with Run=0: ignored; no state change, Err unchanged.
  - Done is always 0 the cycle after any IDLE cycle.
- RUN. Evaluate in priority order:
  1. Run=0: hold T, Step, Ins; End is ignored (stall has priority).
  2. Run=1 and End=1: next cycle IDLE, T=0, Ins=0, Step=0, Busy=0, Done=1 for exactly one cycle.
  3. Run=1, End=0, T[NSTEPS-1]=1: overflow. Next cycle IDLE, all buses 0, Err=1, Done=0.
  4. Otherwise: T shifts left by one, Step increments by 1, Ins held.
- Start and Opcode are ignored while in RUN.
- Opcode is latched only on acceptance; later changes do not affect Ins.
- Back-to-back instructions: Start is accepted in the IDLE cycle where Done=1. Minimum spacing is one idle cycle between the last T step and the next T=1.
- Invariants:
  - T has at most one bit set.
  - Step equals the index of the set bit.
  - Ins is one-hot whenever Busy=1 and zero whenever Busy=0.
- Err clears only on an accepted legal Start or on reset.
- With the encoder's End=T[5], an instruction occupies 6 RUN cycles (T[0]..T[5]) and Done follows on the 7th.

Test Plan:
- Reset: Resetn=0 for 2 cycles with Start=1, Opcode=0 -> T=0, Ins=0, Busy=0, Done=0, Err=0. Release, no Start -> outputs unchanged.
- Normal Sub with the encoder loop (End driven from T[5]): Start=1, Opcode=1, Run=1 -> next cycle T=16'h0001, Ins=4'b0010. T steps through 0002, 0004, 0008, 0010, 0020 over the next 5 cycles. Then T=0, Done=1 for one cycle, Busy=0.
- Stall: during Mul (Opcode=2) at T=16'h0008 drive Run=0 for 3 cycles with End=1 pulsed once -> T holds 0008, Step=3, no completion. Run=1 -> T=0010 next cycle.
- Illegal opcode: Start=1, Opcode=4'd7 -> stays IDLE, T=0, Err=1. Then Start with Opcode=3 -> Err=0, Ins=4'b1000, T=1.
- Overflow: End tied 0, Start with Opcode=0 -> T reaches 16'h8000 (Step=15). Next cycle T=0, Busy=0, Err=1, Done=0.
- Reset mid-instruction and back-to-back: at T=16'h0004 assert Resetn=0 -> all outputs 0 next cycle. After release, run two Add instructions with Start held high -> second T=1 appears exactly one cycle after the Done pulse.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: one-hot time-step generator and opcode decoder driving the T/Ins/End control interface
module step_sequencer #(
   parameter int NSTEPS = 16,
   parameter int OPW = 4
) (
   input  logic              Clk,
   input  logic              Resetn,
   input  logic              Start,
   input  logic [OPW-1:0]    Opcode,
   input  logic              Run,
   input  logic              End,
   output logic [NSTEPS-1:0] T,
   output logic [3:0]        Ins,
   output logic [3:0]        Step,
   output logic              Busy,
   output logic              Done,
   output logic              Err
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [NSTEPS-1:0] t_n;
   logic [3:0] ins_n, step_n;
   logic done_n, err_n;
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         state <= IDLE;
         T     <= '0;
         Ins   <= '0;
         Step  <= '0;
         Done  <= 1'b0;
         Err   <= 1'b0;
      end else begin
         state <= state_n;
         T     <= t_n;
         Ins   <= ins_n;
         Step  <= step_n;
         Done  <= done_n;
         Err   <= err_n;
      end
   end
   always_comb begin
      state_n = state;
      t_n     = T;
      ins_n   = Ins;
      step_n  = Step;
      done_n  = 1'b0;
      err_n   = Err;
      if (state == IDLE) begin
         if (Start && Run) begin
            if (Opcode <= OPW'(3)) begin
               state_n = RUN;
               t_n     = NSTEPS'(1);
               step_n  = '0;
               ins_n   = 4'b0001 << Opcode[1:0];
               err_n   = 1'b0;
            end else begin
               err_n = 1'b1;
            end
         end
      end else if (Run) begin
         // stall (Run=0) outranks End, so End is only honoured here
         if (End || T[NSTEPS-1]) begin
            state_n = IDLE;
            t_n     = '0;
            ins_n   = '0;
            step_n  = '0;
            done_n  = End;
            err_n   = End ? Err : 1'b1;
         end else begin
            t_n    = T << 1;
            step_n = Step + 4'd1;
         end
      end
   end
   assign Busy = (state == RUN);
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed and randomized checks of step_sequencer against a behavioural model
module tb_step_sequencer;
   logic        Clk = 1'b0;
   logic        Resetn, Start, Run, end_drv, loop;
   logic [3:0]  Opcode;
   logic        End;
   logic [15:0] T;
   logic [3:0]  Ins, Step;
   logic        Busy, Done, Err;
   int errors = 0;
   int checks = 0;
   bit valid = 0;
   bit m_busy, m_done, m_err;
   int m_step, m_op;

   assign End = loop ? T[5] : end_drv;

   step_sequencer #(.NSTEPS(16), .OPW(4)) dut (
      .Clk(Clk), .Resetn(Resetn), .Start(Start), .Opcode(Opcode), .Run(Run), .End(End),
      .T(T), .Ins(Ins), .Step(Step), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare against the model, then advance the model with the inputs the next posedge will see
   always @(negedge Clk) begin
      if (valid) begin
         chk("model_T", {16'h0, T}, m_busy ? (32'h1 << m_step) : 32'h0);
         chk("model_Ins", {28'h0, Ins}, m_busy ? (32'h1 << m_op) : 32'h0);
         chk("model_Step", {28'h0, Step}, m_busy ? m_step : 0);
         chk("model_Busy", {31'h0, Busy}, {31'h0, m_busy});
         chk("model_Done", {31'h0, Done}, {31'h0, m_done});
         chk("model_Err", {31'h0, Err}, {31'h0, m_err});
      end
      if (!Resetn) begin
         m_busy = 0; m_done = 0; m_err = 0; m_step = 0; m_op = 0;
         valid = 1;
      end else if (!m_busy) begin
         m_done = 0;
         if (Start && Run) begin
            if (Opcode < 4) begin
               m_busy = 1; m_step = 0; m_op = int'(Opcode); m_err = 0;
            end else m_err = 1;
         end
      end else begin
         m_done = 0;
         if (Run) begin
            if (End) begin
               m_busy = 0; m_done = 1;
            end else if (m_step == 15) begin
               m_busy = 0; m_err = 1;
            end else m_step++;
         end
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   initial begin
      int n;
      Resetn = 0; Start = 1; Opcode = 0; Run = 1; end_drv = 0; loop = 0;
      cyc(); cyc();
      chk("rst_T", {16'h0, T}, 0);
      chk("rst_Busy", {31'h0, Busy}, 0);
      chk("rst_Done", {31'h0, Done}, 0);
      chk("rst_Err", {31'h0, Err}, 0);
      Resetn = 1; Start = 0;
      cyc();
      chk("idle_T", {16'h0, T}, 0);
      // Sub with encoder loop End=T[5]
      loop = 1; Start = 1; Opcode = 1;
      cyc();
      chk("sub_T0", {16'h0, T}, 32'h0001);
      chk("sub_Ins", {28'h0, Ins}, 32'h2);
      Start = 0;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk("sub_Tstep", {16'h0, T}, 32'h1 << i);
      end
      cyc();
      chk("sub_done_T", {16'h0, T}, 0);
      chk("sub_Done", {31'h0, Done}, 1);
      chk("sub_Busy", {31'h0, Busy}, 0);
      cyc();
      chk("sub_Done_pulse", {31'h0, Done}, 0);
      // Stall during Mul
      loop = 0; Start = 1; Opcode = 2;
      cyc();
      Start = 0;
      cyc(); cyc(); cyc();
      chk("mul_T8", {16'h0, T}, 32'h0008);
      Run = 0; end_drv = 1;
      cyc();
      end_drv = 0;
      cyc(); cyc();
      chk("stall_T", {16'h0, T}, 32'h0008);
      chk("stall_Step", {28'h0, Step}, 3);
      chk("stall_Done", {31'h0, Done}, 0);
      chk("stall_Busy", {31'h0, Busy}, 1);
      Run = 1;
      cyc();
      chk("resume_T", {16'h0, T}, 32'h0010);
      end_drv = 1;
      cyc();
      end_drv = 0;
      // Illegal opcode then legal Div
      Start = 1; Opcode = 7;
      cyc();
      chk("ill_T", {16'h0, T}, 0);
      chk("ill_Err", {31'h0, Err}, 1);
      chk("ill_Busy", {31'h0, Busy}, 0);
      Opcode = 3;
      cyc();
      chk("div_Err", {31'h0, Err}, 0);
      chk("div_Ins", {28'h0, Ins}, 32'h8);
      chk("div_T", {16'h0, T}, 1);
      Start = 0; end_drv = 1;
      cyc();
      end_drv = 0;
      // Overflow
      Start = 1; Opcode = 0;
      cyc();
      Start = 0;
      repeat (15) cyc();
      chk("ovf_T15", {16'h0, T}, 32'h8000);
      chk("ovf_Step", {28'h0, Step}, 15);
      cyc();
      chk("ovf_T", {16'h0, T}, 0);
      chk("ovf_Busy", {31'h0, Busy}, 0);
      chk("ovf_Err", {31'h0, Err}, 1);
      chk("ovf_Done", {31'h0, Done}, 0);
      // Reset mid-instruction
      Start = 1; Opcode = 0;
      cyc();
      Start = 0;
      cyc(); cyc();
      chk("mid_T4", {16'h0, T}, 32'h0004);
      Resetn = 0;
      cyc();
      chk("mid_rst_T", {16'h0, T}, 0);
      chk("mid_rst_Busy", {31'h0, Busy}, 0);
      chk("mid_rst_Err", {31'h0, Err}, 0);
      Resetn = 1;
      // Back-to-back Adds with Start held
      loop = 1; Start = 1; Opcode = 0;
      cyc();
      chk("b2b_T1", {16'h0, T}, 1);
      n = 0;
      while (Done !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk("b2b_done_seen", {31'h0, Done}, 1);
      cyc();
      chk("b2b_T1_again", {16'h0, T}, 1);
      chk("b2b_Ins", {28'h0, Ins}, 1);
      Start = 0;
      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) loop = $urandom_range(0, 1);
         Resetn = ($urandom_range(0, 59) != 0);
         Start = $urandom_range(0, 1);
         Opcode = 4'($urandom_range(0, 7));
         Run = ($urandom_range(0, 4) != 0);
         end_drv = ($urandom_range(0, 7) == 0);
         cyc();
      end
      Resetn = 1; Start = 0;
      cyc(); cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
